vib_slot_sequencer: RTL

Time-slot controller that shares one vibrato datapath (fnum/dvb in, vib_val out, fixed pipeline latency) across all operator slots of a sample. On each sample tick it sweeps the slots in order, fetches each slot's fnum/dvb from the register file, feeds the datapath one slot per cycle, and tags each returning vib_val with its slot. After the sweep it issues the LFO advance pulse, so every slot of a sample sees the same LFO phase. It sits between the register file and the vibrato/phase-increment stage.

---
 rtl/vib_slot_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vib_slot_sequencer.sv
// Time-slot sequencer sharing one vibrato datapath across all operator slots of a sample.
// Sweeps slots once per sample tick, tags returning results, then pulses the LFO advance.
module vib_slot_sequencer #(
   parameter int NUM_SLOTS      = 18,
   parameter int REG_FNUM_WIDTH = 10,
   parameter int VIB_VAL_WIDTH  = 3,
   parameter int VIB_LATENCY    = 2,
   parameter int SLOT_W         = $clog2(NUM_SLOTS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_clk_en,
   output logic [SLOT_W-1:0]         rd_slot,
   output logic                      rd_en,
   input  logic [REG_FNUM_WIDTH-1:0] fnum_in,
   input  logic                      dvb_in,
   output logic [REG_FNUM_WIDTH-1:0] vib_fnum,
   output logic                      vib_dvb,
   output logic                      lfo_tick,
   input  logic [VIB_VAL_WIDTH-1:0]  vib_val_in,
   output logic                      res_valid,
   output logic [SLOT_W-1:0]         res_slot,
   output logic [VIB_VAL_WIDTH-1:0]  res_vib_val,
   output logic                      sweep_done,
   output logic                      busy,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_TICK  = 2'd3
   } state_t;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   state_t            state_r;
   state_t            state_s;
   logic [SLOT_W-1:0] slot_cnt_r;
   logic              pending_r;
   logic [VIB_LATENCY:0] tag_vld_r;
   logic [SLOT_W-1:0] tag_slot_r [0:VIB_LATENCY];
   logic              start_s;
   logic              issue_s;
   logic              tick_busy_s;
   logic              pop_vld_s;
   logic              pop_last_s;

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_s     = state_r;
      start_s     = 1'b0;
      issue_s     = (state_r == ST_ISSUE);
      tick_busy_s = sample_clk_en && (state_r != ST_IDLE);
      pop_vld_s   = tag_vld_r[VIB_LATENCY];
      pop_last_s  = tag_vld_r[VIB_LATENCY] && (tag_slot_r[VIB_LATENCY] == LAST_SLOT);
      case (state_r)
         ST_IDLE: begin
            if (sample_clk_en || pending_r) begin
               state_s = ST_ISSUE;
               start_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (slot_cnt_r == LAST_SLOT) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         // sweep_done marks the cycle the last result is on the outputs
         ST_DRAIN: begin
            if (sweep_done) begin
               state_s = ST_TICK;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_TICK: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   assign rd_en   = (state_r == ST_ISSUE);
   assign rd_slot = (state_r == ST_ISSUE) ? slot_cnt_r : {SLOT_W{1'b0}};

   // State, slot counter, tag pipe and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         slot_cnt_r  <= {SLOT_W{1'b0}};
         pending_r   <= 1'b0;
         overrun     <= 1'b0;
         tag_vld_r   <= {(VIB_LATENCY + 1){1'b0}};
         for (int i = 0; i <= VIB_LATENCY; i++) begin
            tag_slot_r[i] <= {SLOT_W{1'b0}};
         end
         vib_fnum    <= {REG_FNUM_WIDTH{1'b0}};
         vib_dvb     <= 1'b0;
         lfo_tick    <= 1'b0;
         res_valid   <= 1'b0;
         res_slot    <= {SLOT_W{1'b0}};
         res_vib_val <= {VIB_VAL_WIDTH{1'b0}};
         sweep_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_r <= state_s;

         if (start_s) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
         end else if (issue_s && (slot_cnt_r != LAST_SLOT)) begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
         end

         // A busy tick is remembered once; the sweep start consumes it
         if (start_s) begin
            pending_r <= 1'b0;
         end else if (tick_busy_s) begin
            pending_r <= 1'b1;
         end

         if (tick_busy_s) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end

         tag_vld_r[0]  <= issue_s;
         tag_slot_r[0] <= slot_cnt_r;
         for (int i = 1; i <= VIB_LATENCY; i++) begin
            tag_vld_r[i]  <= tag_vld_r[i-1];
            tag_slot_r[i] <= tag_slot_r[i-1];
         end

         if (issue_s) begin
            vib_fnum <= fnum_in;
            vib_dvb  <= dvb_in;
         end

         res_valid  <= pop_vld_s;
         sweep_done <= pop_last_s;
         if (pop_vld_s) begin
            res_slot    <= tag_slot_r[VIB_LATENCY];
            res_vib_val <= vib_val_in;
         end

         lfo_tick <= (state_s == ST_TICK);
         busy     <= (state_s != ST_IDLE);
      end
   end

endmodule
